// File: rtl/vect_lane_serializer_if.sv
// vect_lane_serializer_if: vector-in / beat-out handshake bundle for the lane serializer.
interface vect_lane_serializer_if #(
    parameter int N  = 24,
    parameter int M  = 6,
    parameter int AW = 16
);
    logic           vec_valid;
    logic           vec_ready;
    logic [N*M-1:0] vec_data;
    logic [AW-1:0]  vec_addr;
    logic [M-1:0]   vec_mask;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_data;
    logic [AW-1:0]  out_addr;
    logic           out_last;
    logic           busy;
    modport master (
        output vec_valid, vec_data, vec_addr, vec_mask, out_ready,
        input  vec_ready, out_valid, out_data, out_addr, out_last, busy
    );
    modport slave (
        input  vec_valid, vec_data, vec_addr, vec_mask, out_ready,
        output vec_ready, out_valid, out_data, out_addr, out_last, busy
    );
endinterface

// File: rtl/vect_lane_serializer.sv
// vect_lane_serializer: drains a masked M-lane vector into N-bit beats, one enabled lane
// per beat, each tagged with base address + lane index.
module vect_lane_serializer #(
    parameter int N  = 24,
    parameter int M  = 6,
    parameter int AW = 16
) (
    input logic clk,
    input logic rst,
    vect_lane_serializer_if.slave bus
);
    localparam int IW = $clog2(M);
    typedef enum logic {IDLE, SEND} state_t;
    state_t         state_q, state_d;
    logic [N*M-1:0] data_q, data_d;
    logic [AW-1:0]  base_q, base_d;
    logic [M-1:0]   mask_q, mask_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [N-1:0]   out_data_q, out_data_d;
    logic [AW-1:0]  out_addr_q, out_addr_d;
    logic           out_last_q, out_last_d;
    logic           acc, adv, fin, load;
    logic [IW:0]    from;
    logic [IW-1:0]  nidx;
    logic [N*M-1:0] sel_data;
    logic [AW-1:0]  sel_base;
    logic [M-1:0]   sel_mask;
    // One search serves both a fresh vector (from lane 0) and advancing past the current lane.
    always_comb begin
        acc      = state_q == IDLE && bus.vec_valid && |bus.vec_mask;
        adv      = state_q == SEND && bus.out_ready && !out_last_q;
        fin      = state_q == SEND && bus.out_ready && out_last_q;
        load     = acc || adv;
        sel_data = acc ? bus.vec_data : data_q;
        sel_base = acc ? bus.vec_addr : base_q;
        sel_mask = acc ? bus.vec_mask : mask_q;
        from     = acc ? '0 : {1'b0, idx_q} + 1'b1;
        nidx     = '0;
        for (int i = M - 1; i >= 0; i--)
            if (sel_mask[i] && i >= int'(from)) nidx = IW'(i);
        state_d    = acc ? SEND : fin ? IDLE : state_q;
        data_d     = sel_data;
        base_d     = sel_base;
        mask_d     = sel_mask;
        idx_d      = load ? nidx : idx_q;
        out_data_d = load ? sel_data[nidx*N +: N] : fin ? '0 : out_data_q;
        out_addr_d = load ? sel_base + AW'(nidx) : fin ? '0 : out_addr_q;
        out_last_d = load ? ~|((sel_mask >> nidx) >> 1) : fin ? 1'b0 : out_last_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            base_q     <= '0;
            mask_q     <= '0;
            idx_q      <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            base_q     <= base_d;
            mask_q     <= mask_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
            out_addr_q <= out_addr_d;
            out_last_q <= out_last_d;
        end
    end
    assign bus.vec_ready = state_q == IDLE;
    assign bus.out_valid = state_q == SEND;
    assign bus.busy      = state_q == SEND;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_vect_lane_serializer.sv
// tb_vect_lane_serializer: directed and random vectors checked against a queue of expected beats.
module tb_vect_lane_serializer;
    localparam int N  = 24;
    localparam int M  = 6;
    localparam int AW = 16;
    logic clk = 1'b0;
    logic rst;
    int total = 0, passed = 0;
    int mode = 0, pops = 0, stalls = 0;
    bit prev_stall = 0;
    logic [N+AW:0] exp_q[$];
    logic [N*M-1:0] full_vec;
    vect_lane_serializer_if #(.N(N), .M(M), .AW(AW)) bus ();
    vect_lane_serializer #(.N(N), .M(M), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) $display("FAIL %s got=%0h want=%0h", tag, got, want);
        else passed++;
    endtask
    task automatic tick();
        @(negedge clk);
        #1;
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_data"}, 64'(bus.out_data), 64'd0);
        chk({tag, "_addr"}, 64'(bus.out_addr), 64'd0);
        chk({tag, "_last"}, 64'(bus.out_last), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_vready"}, 64'(bus.vec_ready), 64'd1);
    endtask
    task automatic send(input logic [N*M-1:0] d, input logic [AW-1:0] a, input logic [M-1:0] m);
        int n = 0;
        int hi = -1;
        logic [AW-1:0] la;
        while (!bus.vec_ready && n < 50) begin tick(); n++; end
        chk("vec_ready_wait", 64'(bus.vec_ready), 64'd1);
        for (int i = 0; i < M; i++) if (m[i]) hi = i;
        for (int i = 0; i < M; i++)
            if (m[i]) begin
                la = a + AW'(i);
                exp_q.push_back({d[i*N +: N], la, i == hi});
            end
        pops = 0;
        stalls = 0;
        bus.vec_data = d;
        bus.vec_addr = a;
        bus.vec_mask = m;
        bus.vec_valid = 1'b1;
        tick();
        bus.vec_valid = 1'b0;
        if (m != 0) chk("first_beat_latency", 64'(bus.out_valid), 64'd1);
        else begin
            chk("drop_valid", 64'(bus.out_valid), 64'd0);
            chk("drop_busy", 64'(bus.busy), 64'd0);
            chk("drop_vready", 64'(bus.vec_ready), 64'd1);
        end
    endtask
    task automatic drain(input int want);
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin tick(); n++; end
        chk("drain_timeout", 64'(n < 200), 64'd1);
        if (want >= 0) chk("drain_cycles", 64'(n), 64'(want));
        chk("ready_after", 64'(bus.vec_ready), 64'd1);
    endtask
    // Beat monitor: picks out_ready for the coming edge, then scores the visible beat.
    initial begin
        logic rdy;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                continue;
            end
            rdy = 1'b1;
            if (mode == 1) rdy = $urandom_range(0, 3) != 0;
            if (mode == 2 && bus.out_valid && pops == 2 && stalls < 3) begin
                rdy = 1'b0;
                stalls++;
            end
            bus.out_ready = rdy;
            if (prev_stall) chk("hold_valid", 64'(bus.out_valid), 64'd1);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) chk("beat_pending", 64'(exp_q.size()), 64'd1);
                else begin
                    chk("beat", 64'({bus.out_data, bus.out_addr, bus.out_last}), 64'(exp_q[0]));
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
            prev_stall = bus.out_valid && !rdy;
        end
    end
    initial begin
        logic [N*M-1:0] rd;
        int n;
        full_vec = {24'd52, 24'd86, 24'd98, 24'd33, 24'd45, 24'd12};
        rst = 1'b1;
        bus.vec_valid = 1'b0;
        bus.vec_data = '0;
        bus.vec_addr = '0;
        bus.vec_mask = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        chk_idle("por");
        rst = 1'b0;
        tick();
        send(full_vec, 16'h0100, 6'h3F);
        drain(6);
        mode = 2;
        send(full_vec, 16'h0100, 6'h3F);
        drain(9);
        mode = 0;
        send(full_vec, 16'h0100, 6'b101001);
        drain(3);
        send(full_vec, 16'h0100, 6'h00);
        tick();
        chk("mask0_quiet", 64'({bus.out_valid, bus.busy, bus.vec_ready}), 64'b001);
        send(full_vec, 16'h0100, 6'h3F);
        drain(6);
        send(full_vec, 16'hFFFE, 6'h3F);
        drain(6);
        send(full_vec, 16'h0200, 6'h3F);
        n = 0;
        while (pops < 3 && n < 50) begin tick(); n++; end
        chk("reach_beat4", 64'(pops), 64'd3);
        tick();
        chk("beat4_addr", 64'(bus.out_addr), 64'h0203);
        #2 rst = 1'b1;
        #1 chk_idle("mid_reset");
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        chk_idle("post_reset");
        send(full_vec, 16'h0300, 6'h3F);
        drain(6);
        mode = 1;
        for (int v = 0; v < 40; v++) begin
            for (int i = 0; i < M; i++) rd[i*N +: N] = N'($urandom);
            send(rd, AW'($urandom), M'($urandom));
            drain(-1);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
